// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, index width
// and the LEN-byte decoding helper.
// Used by: program_loader (top).
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_SUM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // One bit wider than the address so that a 256-byte frame can be counted.
    localparam int unsigned IDX_W = 9;

    // A LEN byte of 0x00 stands for a 256-byte payload.
    function automatic logic [IDX_W-1:0] frame_len(input logic [7:0] len_byte);
        return (len_byte == 8'h00) ? 9'd256 : {1'b0, len_byte};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Bundle between a byte-stream source / program store / CPU reset logic and
// the program loader.
// slave  : loader side (consumes the stream, drives store writes and CPU hold)
// master : environment side (drives the stream and reload)
interface program_loader_if;
    logic       in_vld;     // source presents a byte
    logic [7:0] in_dat;     // stream byte
    logic       in_rdy;     // loader accepts this cycle
    logic       reload;     // restart framing at LEN
    logic       prog_we;    // one-cycle program store write strobe
    logic [7:0] prog_addr;  // program store write address
    logic [7:0] prog_dat;   // program store write data
    logic       cpu_hold;   // 1 = CPU held in reset
    logic       done;       // load finished with good checksum
    logic       error;      // checksum mismatch or timeout

    modport slave (
        input  in_vld, in_dat, reload,
        output in_rdy, prog_we, prog_addr, prog_dat, cpu_hold, done, error
    );

    modport master (
        output in_vld, in_dat, reload,
        input  in_rdy, prog_we, prog_addr, prog_dat, cpu_hold, done, error
    );
endinterface

// File: rtl/program_loader_timer.sv
// Mid-frame idle timer: counts cycles while enabled, cleared on request.
// Ports: i_clk, i_reset (async, active-high), i_clr, i_en, o_expired.
// o_expired is combinational and fires in the idle cycle whose count would
// bring the timer to TIMEOUT, so the FSM leaves on that same edge.
module program_loader_timer #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // TIMEOUT of zero disables the check entirely.
    assign o_expired = (TIMEOUT != 0) && i_en && (r_cnt == LIMIT);
endmodule

// File: rtl/program_loader.sv
// Program store writer: accepts LEN, DATA[0..N-1], SUM over valid/ready,
// writes DATA to addresses 0..N-1 and releases the CPU on a good checksum.
// Ports: i_clk, i_reset (async, active-high), bus (program_loader_if.slave).
import program_loader_pkg::*;

module program_loader #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    program_loader_if.slave    bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_len;
    logic [7:0]       r_sum;
    logic [IDX_W-1:0] r_idx;
    logic             r_we;
    logic [7:0]       r_addr;
    logic [7:0]       r_dat;
    logic             r_hold;
    logic             r_done;
    logic             r_err;

    logic w_framing;
    logic w_loading;
    logic w_rdy;
    logic w_accept;
    logic w_last;
    logic w_expired;

    assign w_framing = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_SUM);
    assign w_loading = (r_state == ST_DATA) || (r_state == ST_SUM);
    // Reload blocks acceptance in the same cycle so no byte slips into the old frame.
    assign w_rdy     = w_framing & ~bus.reload;
    assign w_accept  = bus.in_vld & w_rdy;
    assign w_last    = (r_idx + 9'd1) == frame_len(r_len);

    program_loader_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_accept | bus.reload | ~w_loading),
        .i_en      (w_loading & ~w_accept & ~bus.reload),
        .o_expired (w_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (bus.reload) begin
            w_state_nxt = ST_LEN;
        end else begin
            case (r_state)
                ST_LEN:  if (w_accept) w_state_nxt = ST_DATA;
                ST_DATA: begin
                    if (w_accept) begin
                        if (w_last) w_state_nxt = ST_SUM;
                    end else if (w_expired) begin
                        w_state_nxt = ST_ERR;
                    end
                end
                ST_SUM: begin
                    if (w_accept)       w_state_nxt = (bus.in_dat == r_sum) ? ST_RUN : ST_ERR;
                    else if (w_expired) w_state_nxt = ST_ERR;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_LEN;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_len  <= '0;
            r_sum  <= '0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_dat  <= '0;
            r_hold <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            // Status flags follow the next state so they change with it.
            r_hold <= (w_state_nxt != ST_RUN);
            r_done <= (w_state_nxt == ST_RUN);
            r_err  <= (w_state_nxt == ST_ERR);
            if (bus.reload) begin
                r_sum <= '0;
                r_idx <= '0;
            end else if (w_accept) begin
                case (r_state)
                    ST_LEN: begin
                        r_len <= bus.in_dat;
                        r_sum <= bus.in_dat;
                        r_idx <= '0;
                    end
                    ST_DATA: begin
                        r_we   <= 1'b1;
                        r_addr <= r_idx[7:0];
                        r_dat  <= bus.in_dat;
                        r_sum  <= r_sum + bus.in_dat;
                        r_idx  <= r_idx + 9'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_rdy    = w_rdy;
    assign bus.prog_we   = r_we;
    assign bus.prog_addr = r_addr;
    assign bus.prog_dat  = r_dat;
    assign bus.cpu_hold  = r_hold;
    assign bus.done      = r_done;
    assign bus.error     = r_err;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader (TIMEOUT=16): directed framing cases plus random
// frames, each compared against an arithmetic frame model (sum mod 256,
// expected write list derived from the payload).
module tb_program_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    program_loader_if bus ();

    program_loader #(.TIMEOUT(16), .CNT_W(8)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] frame_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle cycles: no write may appear.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            check("idle_we", 32'(bus.prog_we), 0);
        end
    endtask

    // Present one byte, expect it accepted at the next edge; then check the strobe.
    task automatic send(input logic [7:0] b, input bit is_data, input logic [7:0] addr);
        bus.in_vld = 1'b1;
        bus.in_dat = b;
        #1;
        check("rdy", 32'(bus.in_rdy), 1);
        check("hold_load", 32'(bus.cpu_hold), 1);
        tick();
        bus.in_vld = 1'b0;
        check("we", 32'(bus.prog_we), is_data ? 1 : 0);
        if (is_data) begin
            check("addr", 32'(bus.prog_addr), 32'(addr));
            check("data", 32'(bus.prog_dat), 32'(b));
        end
    endtask

    task automatic do_reload();
        bus.reload = 1'b1;
        #1;
        check("rdy_reload", 32'(bus.in_rdy), 0);
        tick();
        bus.reload = 1'b0;
        #1;
        check("rl_done", 32'(bus.done), 0);
        check("rl_err", 32'(bus.error), 0);
        check("rl_hold", 32'(bus.cpu_hold), 1);
        check("rl_rdy", 32'(bus.in_rdy), 1);
        check("rl_we", 32'(bus.prog_we), 0);
    endtask

    // Send frame_q as one frame; SUM byte = model checksum + delta.
    task automatic run_frame(input logic [7:0] delta, input int max_gap);
        int n;
        int s;
        logic [7:0] len_b;
        logic [7:0] sum_b;
        bit good;
        n = frame_q.size();
        len_b = 8'(n);                     // 256 encodes as 0x00
        s = int'(len_b);
        foreach (frame_q[i]) s += int'(frame_q[i]);
        sum_b = 8'(s % 256) + delta;
        good = (delta == 8'h00);
        send(len_b, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send(frame_q[i], 1'b1, 8'(i));
        end
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send(sum_b, 1'b0, 8'h00);
        check("done", 32'(bus.done), good ? 1 : 0);
        check("error", 32'(bus.error), good ? 0 : 1);
        check("hold", 32'(bus.cpu_hold), good ? 0 : 1);
        check("rdy_end", 32'(bus.in_rdy), 0);
    endtask

    initial begin
        bus.in_vld = 1'b0;
        bus.in_dat = 8'h00;
        bus.reload = 1'b0;

        // 1. reset state
        #12;
        check("rst_hold", 32'(bus.cpu_hold), 1);
        check("rst_we", 32'(bus.prog_we), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.error), 0);
        rst = 1'b0;
        tick();
        check("rst_rdy", 32'(bus.in_rdy), 1);
        check("rst_hold2", 32'(bus.cpu_hold), 1);

        // 2. good frame, then a byte offered in RUN is ignored
        frame_q = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(8'h00, 0);
        bus.in_vld = 1'b1;
        bus.in_dat = 8'h5A;
        #1;
        check("run_rdy", 32'(bus.in_rdy), 0);
        tick();
        bus.in_vld = 1'b0;
        check("run_we", 32'(bus.prog_we), 0);
        check("run_done", 32'(bus.done), 1);
        do_reload();

        // 3. bad checksum (0x18 instead of 0x19)
        frame_q = '{8'hA1, 8'hB2, 8'hC3};
        run_frame(8'hFF, 0);
        do_reload();

        // 4. 256-byte frame of 0x01, checksum 0x00
        frame_q = {};
        for (int i = 0; i < 256; i++) frame_q.push_back(8'h01);
        run_frame(8'h00, 0);
        check("big_addr_last", 32'(bus.prog_addr), 32'hFF);
        do_reload();

        // 5. reload with a byte presented: not accepted, no write
        send(8'h02, 1'b0, 8'h00);
        send(8'h55, 1'b1, 8'h00);
        bus.in_vld = 1'b1;
        bus.in_dat = 8'h66;
        do_reload();
        bus.in_vld = 1'b0;
        frame_q = '{8'h77};
        run_frame(8'h00, 0);
        do_reload();

        // 6. timeout in DATA: 15 idle cycles survive, 16th errors
        send(8'h04, 1'b0, 8'h00);
        send(8'h10, 1'b1, 8'h00);
        send(8'h20, 1'b1, 8'h01);
        for (int i = 0; i < 15; i++) tick();
        check("to_err_15", 32'(bus.error), 0);
        check("to_rdy_15", 32'(bus.in_rdy), 1);
        tick();
        check("to_err", 32'(bus.error), 1);
        check("to_hold", 32'(bus.cpu_hold), 1);
        check("to_done", 32'(bus.done), 0);
        check("to_rdy", 32'(bus.in_rdy), 0);
        do_reload();
        frame_q = '{8'h01, 8'h02, 8'h03};
        run_frame(8'h00, 0);
        do_reload();

        // timeout while waiting for SUM; LEN idles far longer without error
        idle(40);
        check("len_no_to", 32'(bus.error), 0);
        send(8'h01, 1'b0, 8'h00);
        send(8'hAA, 1'b1, 8'h00);
        for (int i = 0; i < 16; i++) tick();
        check("sum_to_err", 32'(bus.error), 1);
        do_reload();

        // async reset mid-frame
        send(8'h05, 1'b0, 8'h00);
        send(8'h11, 1'b1, 8'h00);
        send(8'h22, 1'b1, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        check("ar_hold", 32'(bus.cpu_hold), 1);
        check("ar_we", 32'(bus.prog_we), 0);
        check("ar_addr", 32'(bus.prog_addr), 0);
        rst = 1'b0;
        tick();
        frame_q = '{8'h33, 8'h44};
        run_frame(8'h00, 0);
        do_reload();

        // random frames with gaps below the timeout
        for (int f = 0; f < 20; f++) begin
            int n;
            logic [7:0] delta;
            n = $urandom_range(1, 24);
            frame_q = {};
            for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom));
            delta = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            run_frame(delta, (f % 2 == 0) ? 15 : 2);
            do_reload();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
